// File: rtl/axi_rd_port_arbiter_if.sv
// Shim-side read channel of the refill arbiter: tagged request out, tagged beats back.
interface axi_rd_port_arbiter_if #(
  parameter int IdWidth   = 4,
  parameter int BlenWidth = 2,
  parameter int PortIdxW  = 1
);
  logic                        shim_req;
  logic                        shim_gnt;
  logic [63:0]                 shim_addr;
  logic [BlenWidth-1:0]        shim_blen;
  logic [1:0]                  shim_size;
  logic [IdWidth+PortIdxW-1:0] shim_id;
  logic                        shim_rdy;
  logic                        shim_valid;
  logic                        shim_last;
  logic [63:0]                 shim_data;
  logic [IdWidth+PortIdxW-1:0] shim_rid;
  logic                        shim_exokay;

  modport master (
    output shim_req, shim_addr, shim_blen, shim_size, shim_id, shim_rdy,
    input  shim_gnt, shim_valid, shim_last, shim_data, shim_rid, shim_exokay
  );

  modport slave (
    input  shim_req, shim_addr, shim_blen, shim_size, shim_id, shim_rdy,
    output shim_gnt, shim_valid, shim_last, shim_data, shim_rid, shim_exokay
  );
endinterface

// File: rtl/axi_rd_port_arbiter.sv
// Round-robin sharing of the shim read port between refill requesters, with
// port-tagged IDs steering beats back and a per-port in-flight burst cap.
//
// state | meaning
// IDLE  | pick next eligible requester round-robin, latch its request
// REQ   | present latched request to the shim until it is granted
module axi_rd_port_arbiter #(
  parameter int NumPorts       = 2,
  parameter int IdWidth        = 4,
  parameter int BlenWidth      = 2,
  parameter int MaxOutstanding = 2,
  parameter int PortIdxW       = $clog2(NumPorts)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumPorts-1:0]           req_i,
  output logic [NumPorts-1:0]           gnt_o,
  input  logic [NumPorts*64-1:0]        addr_i,
  input  logic [NumPorts*BlenWidth-1:0] blen_i,
  input  logic [NumPorts*2-1:0]         size_i,
  input  logic [NumPorts*IdWidth-1:0]   id_i,
  output logic [NumPorts-1:0]           valid_o,
  output logic                          last_o,
  output logic [63:0]                   data_o,
  output logic [IdWidth-1:0]            id_o,
  output logic                          exokay_o,
  output logic                          busy_o,
  output logic                          err_o,
  axi_rd_port_arbiter_if.master         shim
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int TagW = IdWidth + PortIdxW;

  typedef enum logic {IDLE, REQ} state_e;

  state_e               state_q, state_d;
  logic [PortIdxW-1:0]  rr_q, rr_d, sel_q, sel_d;
  logic [63:0]          addr_q, addr_d;
  logic [BlenWidth-1:0] blen_q, blen_d;
  logic [1:0]           size_q, size_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [CntW-1:0]      cnt_q [NumPorts];
  logic [CntW-1:0]      cnt_d [NumPorts];
  logic                 err_q;

  logic [NumPorts-1:0]  elig;
  logic                 pick_found;
  logic [PortIdxW-1:0]  pick_idx;
  logic                 grant;
  logic [PortIdxW-1:0]  ret_idx;
  logic                 ret_in_range, ret_zero, stray, ret_dec;
  logic                 any_out;

  always_comb begin
    elig = '0;
    for (int p = 0; p < NumPorts; p++) begin
      elig[p] = req_i[p] && (32'(cnt_q[p]) < MaxOutstanding);
    end
  end

  always_comb begin
    logic [PortIdxW-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      cand = PortIdxW'((int'(rr_q) + i) % NumPorts);
      if (!pick_found && elig[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    blen_d  = blen_q;
    size_d  = size_q;
    id_d    = id_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = REQ;
          sel_d   = pick_idx;
          for (int p = 0; p < NumPorts; p++) begin
            if (PortIdxW'(p) == pick_idx) begin
              addr_d = addr_i[p*64 +: 64];
              blen_d = blen_i[p*BlenWidth +: BlenWidth];
              size_d = size_i[p*2 +: 2];
              id_d   = id_i[p*IdWidth +: IdWidth];
            end
          end
        end
      end
      REQ: begin
        // A reset landing on the grant cycle abandons the request outright.
        if (shim.shim_gnt && !rst_i) begin
          grant   = 1'b1;
          state_d = IDLE;
          rr_d    = (sel_q == PortIdxW'(NumPorts - 1)) ? '0 : sel_q + PortIdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o = '0;
    if (grant) gnt_o[sel_q] = 1'b1;
  end

  assign ret_idx      = shim.shim_rid[TagW-1:IdWidth];
  assign ret_in_range = 32'(ret_idx) < NumPorts;
  assign ret_zero     = ret_in_range ? (cnt_q[ret_idx] == '0) : 1'b1;
  assign stray        = shim.shim_valid && (!ret_in_range || (shim.shim_last && ret_zero));
  assign ret_dec      = shim.shim_valid && shim.shim_last && !stray;

  always_comb begin
    valid_o = '0;
    if (shim.shim_valid && !stray) valid_o[ret_idx] = 1'b1;
  end

  // Grant and last beat on the same port in one cycle cancel out.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      cnt_d[p] = cnt_q[p]
               + CntW'(grant && (sel_q == PortIdxW'(p)))
               - CntW'(ret_dec && (ret_idx == PortIdxW'(p)));
    end
  end

  always_comb begin
    any_out = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      if (cnt_q[p] != '0) any_out = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      blen_q  <= '0;
      size_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      for (int p = 0; p < NumPorts; p++) cnt_q[p] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      blen_q  <= blen_d;
      size_q  <= size_d;
      id_q    <= id_d;
      err_q   <= err_q | stray;
      cnt_q   <= cnt_d;
    end
  end

  assign shim.shim_req  = (state_q == REQ) && !rst_i;
  assign shim.shim_addr = addr_q;
  assign shim.shim_blen = blen_q;
  assign shim.shim_size = size_q;
  assign shim.shim_id   = {sel_q, id_q};
  assign shim.shim_rdy  = 1'b1;

  assign last_o   = shim.shim_last;
  assign data_o   = shim.shim_data;
  assign id_o     = shim.shim_rid[IdWidth-1:0];
  assign exokay_o = shim.shim_exokay;
  assign busy_o   = (state_q == REQ) || any_out;
  assign err_o    = err_q;

endmodule

// File: tb/tb_axi_rd_port_arbiter.sv
// Randomized bench for axi_rd_port_arbiter against a transaction-level model
// (pending request + per-port queues of in-flight bursts).
module tb_axi_rd_port_arbiter;

  localparam int NumPorts       = 2;
  localparam int IdWidth        = 4;
  localparam int BlenWidth      = 2;
  localparam int MaxOutstanding = 2;
  localparam int PortIdxW       = $clog2(NumPorts);
  localparam int TagW           = IdWidth + PortIdxW;

  typedef struct packed {
    logic [63:0]          addr;
    logic [BlenWidth-1:0] blen;
    logic [1:0]           size;
    logic [IdWidth-1:0]   id;
  } txn_t;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic [NumPorts-1:0]           req_i;
  logic [NumPorts-1:0]           gnt_o;
  logic [NumPorts*64-1:0]        addr_i;
  logic [NumPorts*BlenWidth-1:0] blen_i;
  logic [NumPorts*2-1:0]         size_i;
  logic [NumPorts*IdWidth-1:0]   id_i;
  logic [NumPorts-1:0]           valid_o;
  logic                          last_o;
  logic [63:0]                   data_o;
  logic [IdWidth-1:0]            id_o;
  logic                          exokay_o;
  logic                          busy_o;
  logic                          err_o;

  axi_rd_port_arbiter_if #(.IdWidth(IdWidth), .BlenWidth(BlenWidth), .PortIdxW(PortIdxW)) shim_if ();

  axi_rd_port_arbiter #(
    .NumPorts(NumPorts), .IdWidth(IdWidth), .BlenWidth(BlenWidth),
    .MaxOutstanding(MaxOutstanding), .PortIdxW(PortIdxW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .blen_i(blen_i), .size_i(size_i), .id_i(id_i),
    .valid_o(valid_o), .last_o(last_o), .data_o(data_o), .id_o(id_o),
    .exokay_o(exokay_o), .busy_o(busy_o), .err_o(err_o), .shim(shim_if)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // requester and return-generator state
  bit   want [NumPorts];
  txn_t rq   [NumPorts];
  bit   rb_active;
  int   rb_port;
  int   rb_left;
  int   p_req, p_gnt, p_ret;
  bit   force_stray;

  // reference model
  bit   m_pending;
  int   m_sel;
  txn_t m_txn;
  int   m_rr;
  bit   m_err;
  txn_t outq [NumPorts][$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    m_pending = 0;
    m_rr      = 0;
    m_err     = 0;
    rb_active = 0;
    for (int p = 0; p < NumPorts; p++) begin
      outq[p].delete();
      want[p] = 0;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      rst_i              = 1'b1;
      req_i              = '0;
      shim_if.shim_gnt   = 1'b1;
      shim_if.shim_valid = 1'b0;
      shim_if.shim_last  = 1'b0;
      #1;
      check_val("rst_gnt", 64'(gnt_o), 64'(0));
      check_val("rst_shim_req", 64'(shim_if.shim_req), 64'(0));
    end
    @(posedge clk_i);
    #1;
    rst_i            = 1'b0;
    shim_if.shim_gnt = 1'b0;
    model_clear();
  endtask

  task automatic cycle_step();
    logic [NumPorts-1:0] exp_valid, exp_gnt;
    logic [TagW-1:0]     rid;
    bit                  valid, last, stray, grant, busy, found;
    int                  idx, c;
    int                  cands[$];

    @(negedge clk_i);
    for (int p = 0; p < NumPorts; p++) begin
      if (!want[p] && ($urandom_range(99) < p_req)) begin
        want[p]    = 1;
        rq[p].addr = {$urandom, $urandom};
        rq[p].blen = BlenWidth'($urandom);
        rq[p].size = 2'($urandom);
        rq[p].id   = IdWidth'($urandom);
      end
      req_i[p]                          = want[p];
      addr_i[p*64 +: 64]                = rq[p].addr;
      blen_i[p*BlenWidth +: BlenWidth]  = rq[p].blen;
      size_i[p*2 +: 2]                  = rq[p].size;
      id_i[p*IdWidth +: IdWidth]        = rq[p].id;
    end
    shim_if.shim_gnt = ($urandom_range(99) < p_gnt);

    valid = 0;
    last  = 0;
    rid   = TagW'($urandom);
    if (force_stray) begin
      valid = 1;
      last  = 1;
      rid   = {PortIdxW'(0), IdWidth'(5)};
    end else begin
      if (!rb_active) begin
        for (int p = 0; p < NumPorts; p++) if (outq[p].size() != 0) cands.push_back(p);
        if (cands.size() != 0 && ($urandom_range(99) < p_ret)) begin
          rb_active = 1;
          rb_port   = cands[$urandom_range(cands.size() - 1)];
          rb_left   = int'(outq[rb_port][0].blen) + 1;
        end
      end
      if (rb_active && ($urandom_range(99) < p_ret)) begin
        valid = 1;
        last  = (rb_left == 1);
        rid   = {PortIdxW'(rb_port), outq[rb_port][0].id};
      end
    end
    shim_if.shim_valid  = valid;
    shim_if.shim_last   = last;
    shim_if.shim_rid    = rid;
    shim_if.shim_data   = {$urandom, $urandom};
    shim_if.shim_exokay = 1'($urandom);
    #1;

    idx   = int'(rid[TagW-1:IdWidth]);
    stray = valid && ((idx >= NumPorts) || (last && outq[idx].size() == 0));
    exp_valid = '0;
    if (valid && !stray) exp_valid[idx] = 1'b1;
    grant   = m_pending && shim_if.shim_gnt;
    exp_gnt = '0;
    if (grant) exp_gnt[m_sel] = 1'b1;
    busy = m_pending;
    for (int p = 0; p < NumPorts; p++) if (outq[p].size() != 0) busy = 1;

    check_val("gnt", 64'(gnt_o), 64'(exp_gnt));
    check_val("shim_req", 64'(shim_if.shim_req), 64'(m_pending));
    if (m_pending) begin
      check_val("shim_addr", shim_if.shim_addr, m_txn.addr);
      check_val("shim_blen", 64'(shim_if.shim_blen), 64'(m_txn.blen));
      check_val("shim_size", 64'(shim_if.shim_size), 64'(m_txn.size));
      check_val("shim_id", 64'(shim_if.shim_id), 64'({PortIdxW'(m_sel), m_txn.id}));
    end
    check_val("valid", 64'(valid_o), 64'(exp_valid));
    check_val("last", 64'(last_o), 64'(last));
    check_val("data", data_o, shim_if.shim_data);
    check_val("id_o", 64'(id_o), 64'(rid[IdWidth-1:0]));
    check_val("exokay", 64'(exokay_o), 64'(shim_if.shim_exokay));
    check_val("busy", 64'(busy_o), 64'(busy));
    check_val("err", 64'(err_o), 64'(m_err));
    check_val("shim_rdy", 64'(shim_if.shim_rdy), 64'(1));

    // model state update for the coming edge; eligibility uses pre-edge counts
    if (grant) begin
      outq[m_sel].push_back(m_txn);
      m_rr       = (m_sel + 1) % NumPorts;
      m_pending  = 0;
      want[m_sel] = 0;
    end else if (!m_pending) begin
      found = 0;
      for (int k = 0; k < NumPorts; k++) begin
        c = (m_rr + k) % NumPorts;
        if (!found && want[c] && outq[c].size() < MaxOutstanding) begin
          found     = 1;
          m_pending = 1;
          m_sel     = c;
          m_txn     = rq[c];
        end
      end
    end
    if (valid && !force_stray) begin
      if (last) begin
        rb_active = 0;
        void'(outq[idx].pop_front());
      end else begin
        rb_left--;
      end
    end
    m_err       = m_err | stray;
    force_stray = 0;
  endtask

  task automatic run(input int n, input int rq_pct, input int gnt_pct, input int ret_pct);
    p_req = rq_pct;
    p_gnt = gnt_pct;
    p_ret = ret_pct;
    for (int i = 0; i < n; i++) cycle_step();
  endtask

  task automatic drain();
    bit done;
    done  = 0;
    p_req = 0;
    p_gnt = 100;
    p_ret = 100;
    for (int i = 0; i < 300 && !done; i++) begin
      cycle_step();
      done = !m_pending && !rb_active;
      for (int p = 0; p < NumPorts; p++) if (want[p] || outq[p].size() != 0) done = 0;
    end
    check_val("drain_done", 64'(done), 64'(1));
  endtask

  initial begin
    rst_i = 1'b1;
    req_i = '0;
    addr_i = '0;
    blen_i = '0;
    size_i = '0;
    id_i = '0;
    shim_if.shim_gnt    = 1'b0;
    shim_if.shim_valid  = 1'b0;
    shim_if.shim_last   = 1'b0;
    shim_if.shim_rid    = '0;
    shim_if.shim_data   = '0;
    shim_if.shim_exokay = 1'b0;
    force_stray = 0;
    for (int p = 0; p < NumPorts; p++) rq[p] = '0;
    model_clear();

    do_reset(2);
    run(4, 0, 0, 0);
    run(400, 70, 60, 60);
    run(30, 100, 100, 0);
    run(300, 100, 100, 50);
    run(200, 40, 30, 80);

    // reset while a request is held at the shim
    p_req = 100;
    p_gnt = 0;
    for (int i = 0; i < 10 && !m_pending; i++) cycle_step();
    do_reset(1);
    run(3, 0, 0, 0);

    drain();
    force_stray = 1;
    cycle_step();
    run(5, 0, 0, 0);
    run(200, 70, 60, 60);

    do_reset(2);
    run(4, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_port_arbiter.md
Name: axi_rd_port_arbiter

Overview:
- Shares the single read port of the cache-subsystem AXI shim between NumPorts refill requesters (e.g. I$ refill, PTW, D$ refill).
- Round-robin arbitration across requesters.
- Each requester's ID is tagged with its port index on the way out; the tag steers read beats back to the right requester.
- Per-port outstanding-transaction limit and a return-path error flag.

Parameters:
- NumPorts, 2, number of requesters (>=2).
- IdWidth, 4, requester-side transaction ID width.
- BlenWidth, 2, burst-length field width (beats-1).
- MaxOutstanding, 2, max in-flight bursts per port (>=1).
- PortIdxW, $clog2(NumPorts), derived; shim ID width = IdWidth+PortIdxW.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  NumPorts  per-port read request.
- gnt_o  out  NumPorts  one-cycle grant pulse per port.
- addr_i  in  NumPorts*64  per-port physical address.
- blen_i  in  NumPorts*BlenWidth  per-port burst length-1.
- size_i  in  NumPorts*2  per-port beat size.
- id_i  in  NumPorts*IdWidth  per-port transaction ID.
- valid_o  out  NumPorts  per-port read-beat valid.
- last_o  out  1  last beat (broadcast).
- data_o  out  64  beat data (broadcast).
- id_o  out  IdWidth  returned ID with port tag stripped (broadcast).
- exokay_o  out  1  exclusive-okay (broadcast).
- busy_o  out  1  request pending or any transaction outstanding.
- err_o  out  1  sticky: stray return beat dropped.
- shim_req_o  out  1  request to shim.
- shim_gnt_i  in  1  shim grant.
- shim_addr_o  out  64  address to shim.
- shim_blen_o  out  BlenWidth  burst length to shim.
- shim_size_o  out  2  beat size to shim.
- shim_id_o  out  IdWidth+PortIdxW  tagged ID: {port index, id}.
- shim_rdy_o  out  1  constant 1; returns are never back-pressured.
- shim_valid_i  in  1  beat valid from shim.
- shim_last_i  in  1  last beat from shim.
- shim_data_i  in  64  beat data from shim.
- shim_id_i  in  IdWidth+PortIdxW  returned tagged ID.
- shim_exokay_i  in  1  exclusive-okay from shim.

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - state=IDLE, rr_ptr=0, all counters cnt[p]=0, err_o=0.
  - All outputs 0 except shim_rdy_o=1.
  - Reset mid-request abandons the held request; no grant is issued.
- Eligibility: port p is eligible when req_i[p]=1 and cnt[p]<MaxOutstanding.
- FSM IDLE:
  - If any port is eligible, select the first eligible port scanning from rr_ptr upward, wrapping at NumPorts.
  - Register sel, addr, blen, size and {sel,id}. Go to REQ.
  - No grant is issued in IDLE.
- FSM REQ:
  - shim_req_o=1; all shim request fields come only from the registers.
  - Hold until shim_gnt_i=1. On that cycle:
    - gnt_o[sel]=1 for exactly one cycle;
    - cnt[sel]++;
    - rr_ptr=(sel+1) mod NumPorts;
    - next state IDLE.
  - req_i changes in REQ are ignored; the requester must hold req_i until gnt_o (AXI rule).
- Latency: req_i seen at cycle 0 -> shim_req_o at cycle 1 -> gnt_o earliest at cycle 1 (same cycle as shim_gnt_i). Minimum 2 cycles between consecutive grants.
- Return path (combinational, zero latency):
  - idx = shim_id_i[IdWidth+PortIdxW-1:IdWidth].
  - valid_o[idx] = shim_valid_i; other ports see 0.
  - data_o, last_o, id_o = shim_id_i[IdWidth-1:0], and exokay_o pass through.
  - On shim_valid_i & shim_last_i: cnt[idx]--.
- Stray beat: if idx>=NumPorts, or cnt[idx]==0 on a last beat:
  - drop the beat (no valid_o);
  - no counter change;
  - set err_o (sticky until reset).
- Same-port grant and last-beat return in the same cycle: cnt[p] is unchanged (+1-1). Counters never wrap.
- A port at MaxOutstanding is skipped by arbitration; other ports proceed.
- busy_o = (state==REQ) | (any cnt[p]!=0).

Test Plan:
- Reset then idle: rst_i held 2 cycles, all req_i=0 -> gnt_o=0, shim_req_o=0, busy_o=0, err_o=0, shim_rdy_o=1.
- Single port: port1 req addr 0x8000_0040, blen=1, id=3 at cycle 0 -> cycle 1: shim_req_o=1, shim_addr_o=0x8000_0040, shim_id_o={1,3}. shim_gnt_i=1 at cycle 2 -> gnt_o=2'b10 at cycle 2 only. 2 beats with shim_id_i={1,3} -> valid_o[1] both beats, id_o=3, cnt[1] returns to 0.
- Round robin: both ports request continuously, shim_gnt_i always 1, returns immediate -> grants alternate p0,p1,p0,p1, one grant every 2 cycles.
- Outstanding cap: MaxOutstanding=2, port0 gets 2 grants with no returns -> port0 is no longer granted and port1 is granted. One last beat back to port0 -> port0 granted again.
- Simultaneous: port0 granted in the same cycle as a last beat for port0 -> cnt[0] unchanged, busy_o stays 1.
- Stray return: shim_valid_i=1, shim_last_i=1, shim_id_i={0,5} with cnt[0]=0 -> valid_o=0, err_o=1 from next cycle and held until rst_i.
